seq_detector_param: RTL and testbench

//  Parametrised Moore-type serial pattern detector: generalises the fixed 4-bit

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: parameterised Moore serial pattern detector.
// The state counts how many leading pattern bits are currently matched
// (KMP style). The next-state table is built from PATTERN when the design
// is elaborated. Detection may be overlapping or non-overlapping. A
// data_valid qualifier stalls the detector, and match_count saturates.
module seq_detector_param #(
    parameter int                   PAT_WIDTH = 4,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1101,
    parameter int                   OVERLAP   = 0,
    parameter int                   CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             data_valid,
    input  logic                             data,
    output logic                             detected,
    output logic [$clog2(PAT_WIDTH+1)-1:0]   state,
    output logic [CNT_WIDTH-1:0]             match_count
);

    localparam int                   SW       = $clog2(PAT_WIDTH + 1);
    localparam int                   NSTATE   = 2 ** SW;
    localparam logic [SW-1:0]        DETECT_S = SW'(PAT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    if (PAT_WIDTH < 2 || PAT_WIDTH > 16) begin : g_bad_width
        $error("seq_detector_param: PAT_WIDTH must be in 2..16");
    end

    // Longest pattern prefix that is a suffix of (prefix of length s, then b).
    // Leaving DETECT without overlap restarts from an empty history.
    function automatic logic [SW-1:0] next_of(input int s, input logic b);
        int                   s_eff;
        int                   best;
        int                   idx;
        logic                 ok;
        logic                 seq_bit;
        logic                 pat_bit;
        logic [PAT_WIDTH-1:0] shifted;
        s_eff = (OVERLAP == 0 && s == PAT_WIDTH) ? 0 : s;
        best  = 0;
        for (int k = 1; k <= PAT_WIDTH; k++) begin
            if (k <= s_eff + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx = s_eff + 1 - k + j;
                    if (idx < s_eff) begin
                        shifted = PATTERN >> (PAT_WIDTH - 1 - idx);
                        seq_bit = shifted[0];
                    end else begin
                        seq_bit = b;
                    end
                    shifted = PATTERN >> (PAT_WIDTH - 1 - j);
                    pat_bit = shifted[0];
                    if (seq_bit != pat_bit) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best[SW-1:0];
    endfunction

    logic [SW-1:0] next_on_zero [NSTATE];
    logic [SW-1:0] next_on_one  [NSTATE];
    logic [SW-1:0] next_state;

    // Unreachable encodings above PAT_WIDTH fall back to the idle state.
    for (genvar g = 0; g < NSTATE; g++) begin : g_table
        if (g <= PAT_WIDTH) begin : g_live
            assign next_on_zero[g] = next_of(g, 1'b0);
            assign next_on_one[g]  = next_of(g, 1'b1);
        end else begin : g_dead
            assign next_on_zero[g] = '0;
            assign next_on_one[g]  = '0;
        end
    end

    // Select the table entry for the incoming bit.
    always_comb begin
        next_state = data ? next_on_one[state] : next_on_zero[state];
    end

    // State, Moore output and saturating counter advance only on valid samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= '0;
            detected    <= 1'b0;
            match_count <= '0;
        end else if (data_valid) begin
            state    <= next_state;
            detected <= (next_state == DETECT_S);
            if (next_state == DETECT_S && match_count != CNT_MAX) begin
                match_count <= match_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: self-checking bench for seq_detector_param.
// Four configurations share one input stream. The bench uses a table of
// expected values, hand-written corner sequences, and random stimulus
// compared against a suffix-matching history model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset;
    logic data_valid;
    logic data;

    logic       det0, det1, det2, det3;
    logic [2:0] st0, st1;
    logic [1:0] st2;
    logic [3:0] st3;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    // 10 ns clock period.
    always #5 clk = ~clk;

    seq_detector_param #(.PAT_WIDTH(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .detected(det0), .state(st0), .match_count(cnt0));
    seq_detector_param #(.PAT_WIDTH(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .detected(det1), .state(st1), .match_count(cnt1));
    seq_detector_param #(.PAT_WIDTH(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .detected(det2), .state(st2), .match_count(cnt2));
    seq_detector_param #(.PAT_WIDTH(8), .PATTERN(8'hA5), .OVERLAP(0), .CNT_WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .detected(det3), .state(st3), .match_count(cnt3));

    // Reference model: keep the received bits and find the longest suffix that
    // equals a pattern prefix. Without overlap the history is cleared on a match.
    int          mw   [4] = '{4, 4, 3, 8};
    logic [15:0] mpat [4] = '{16'hD, 16'hD, 16'h7, 16'hA5};
    bit          mov  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int          mmax [4] = '{255, 255, 3, 255};
    logic [63:0] mhist[4];
    int          mlen [4];
    int          mstate[4];
    int          mcnt [4];

    function automatic int longestMatch(input int i);
        int          best;
        logic [63:0] mask;
        best = 0;
        for (int k = 1; k <= mw[i]; k++) begin
            if (k <= mlen[i]) begin
                mask = (64'd1 << k) - 64'd1;
                if ((mhist[i] & mask) == ((64'(mpat[i]) >> (mw[i] - k)) & mask)) best = k;
            end
        end
        return best;
    endfunction

    task automatic modelStep(input logic r, input logic v, input logic d);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                mhist[i] = '0; mlen[i] = 0; mstate[i] = 0; mcnt[i] = 0;
            end else if (v) begin
                mhist[i] = {mhist[i][62:0], d};
                if (mlen[i] < 64) mlen[i]++;
                mstate[i] = longestMatch(i);
                if (mstate[i] == mw[i]) begin
                    if (mcnt[i] < mmax[i]) mcnt[i]++;
                    if (!mov[i]) mlen[i] = 0;
                end
            end
        end
    endtask

    function automatic int dutState(input int i);
        case (i)
            0: return int'(st0);
            1: return int'(st1);
            2: return int'(st2);
            default: return int'(st3);
        endcase
    endfunction

    function automatic int dutDet(input int i);
        case (i)
            0: return int'(det0);
            1: return int'(det1);
            2: return int'(det2);
            default: return int'(det3);
        endcase
    endfunction

    function automatic int dutCnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then settle
    // 1 ns past the edge so outputs can be sampled.
    task automatic applyStimulus(input logic r, input logic v, input logic d);
        reset = r; data_valid = v; data = d;
        @(posedge clk);
        modelStep(r, v, d);
        #1;
    endtask

    typedef struct {
        logic dat;
        int   st_nov;
        logic det_nov;
        int   st_ov;
        logic det_ov;
    } vec_t;

    vec_t        tbl [14];
    logic [15:0] a5a5;

    initial begin
        reset = 1'b1; data_valid = 1'b0; data = 1'b0;

        // Check the reset state of every instance.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset_state%0d", i), dutState(i), 0);
            checkOutput($sformatf("reset_det%0d", i), dutDet(i), 0);
            checkOutput($sformatf("reset_cnt%0d", i), dutCnt(i), 0);
        end

        // Run the stream 1101 0111 0110 10 through both the non-overlap and
        // overlap detectors.
        tbl[0]  = '{1'b1, 1, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b1, 2, 1'b0, 2, 1'b0};
        tbl[2]  = '{1'b0, 3, 1'b0, 3, 1'b0};
        tbl[3]  = '{1'b1, 4, 1'b1, 4, 1'b1};
        tbl[4]  = '{1'b0, 0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1, 1'b0, 1, 1'b0};
        tbl[6]  = '{1'b1, 2, 1'b0, 2, 1'b0};
        tbl[7]  = '{1'b1, 2, 1'b0, 2, 1'b0};
        tbl[8]  = '{1'b0, 3, 1'b0, 3, 1'b0};
        tbl[9]  = '{1'b1, 4, 1'b1, 4, 1'b1};
        tbl[10] = '{1'b1, 1, 1'b0, 2, 1'b0};
        tbl[11] = '{1'b0, 0, 1'b0, 3, 1'b0};
        tbl[12] = '{1'b1, 1, 1'b0, 4, 1'b1};
        tbl[13] = '{1'b0, 0, 1'b0, 0, 1'b0};
        for (int n = 0; n < 14; n++) begin
            applyStimulus(1'b0, 1'b1, tbl[n].dat);
            checkOutput($sformatf("tbl%0d_state_nov", n), int'(st0), tbl[n].st_nov);
            checkOutput($sformatf("tbl%0d_det_nov", n), int'(det0), int'(tbl[n].det_nov));
            checkOutput($sformatf("tbl%0d_state_ov", n), int'(st1), tbl[n].st_ov);
            checkOutput($sformatf("tbl%0d_det_ov", n), int'(det1), int'(tbl[n].det_ov));
        end
        checkOutput("tbl_count_nov", int'(cnt0), 2);
        checkOutput("tbl_count_ov", int'(cnt1), 3);

        // A stall holds the partial match while data toggles.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b0, n[0]);
            checkOutput($sformatf("stall%0d_state", n), int'(st0), 3);
            checkOutput($sformatf("stall%0d_det", n), int'(det0), 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stall_final_det", int'(det0), 1);
        checkOutput("stall_final_cnt", int'(cnt0), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stall_in_detect_det", int'(det0), 1);

        // A reset in the middle of a match discards the partial match.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("midreset_state", int'(st0), 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midreset_after_state", int'(st0), 1);
        checkOutput("midreset_after_det", int'(det0), 0);
        checkOutput("midreset_after_cnt", int'(cnt0), 0);

        // With pattern 111 and overlap, a run of ones redetects on every bit
        // and the 2-bit counter saturates at 3.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("ones%0d_det", n), int'(det2), (n >= 3) ? 1 : 0);
            checkOutput($sformatf("ones%0d_cnt", n), int'(cnt2), (n >= 5) ? 3 : ((n >= 3) ? n - 2 : 0));
        end

        // The 8-bit pattern A5 sent twice, MSB first.
        applyStimulus(1'b1, 1'b0, 1'b0);
        a5a5 = 16'hA5A5;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0, 1'b1, a5a5[15 - n]);
            checkOutput($sformatf("a5_bit%0d_det", n + 1), int'(det3), (n == 7 || n == 15) ? 1 : 0);
        end
        checkOutput("a5_cnt", int'(cnt3), 2);

        // Random stimulus compared against the history model.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("rnd%0d_state%0d", n, i), dutState(i), mstate[i]);
                checkOutput($sformatf("rnd%0d_det%0d", n, i), dutDet(i), (mstate[i] == mw[i]) ? 1 : 0);
                checkOutput($sformatf("rnd%0d_cnt%0d", n, i), dutCnt(i), mcnt[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
